// File: rtl/seed_pkg.sv
// seed_pkg: SEED S-boxes, derived SS0..SS3 G-function tables, FSM state type and LANES check.
package seed_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef logic [255:0][31:0] ss_tbl_t;
  localparam logic [7:0] S1 [256] = '{
    8'ha9,8'h85,8'hd6,8'hd3,8'h54,8'h1d,8'hac,8'h25,8'h5d,8'h43,8'h18,8'h1e,8'h51,8'hfc,8'hca,8'h63,
    8'h28,8'h44,8'h20,8'h9d,8'he0,8'he2,8'hc8,8'h17,8'ha5,8'h8f,8'h03,8'h7b,8'hbb,8'h13,8'hd2,8'hee,
    8'h70,8'h8c,8'h3f,8'ha8,8'h32,8'hdd,8'hf6,8'h74,8'hec,8'h95,8'h0b,8'h57,8'h5c,8'h5b,8'hbd,8'h01,
    8'h24,8'h1c,8'h73,8'h98,8'h10,8'hcc,8'hf2,8'hd9,8'h2c,8'he7,8'h72,8'h83,8'h9b,8'hd1,8'h86,8'hc9,
    8'h60,8'h50,8'ha3,8'heb,8'h0d,8'hb6,8'h9e,8'h4f,8'hb7,8'h5a,8'hc6,8'h78,8'ha6,8'h12,8'haf,8'hd5,
    8'h61,8'hc3,8'hb4,8'h41,8'h52,8'h7d,8'h8d,8'h08,8'h1f,8'h99,8'h00,8'h19,8'h04,8'h53,8'hf7,8'he1,
    8'hfd,8'h76,8'h2f,8'h27,8'hb0,8'h8b,8'h0e,8'hab,8'ha2,8'h6e,8'h93,8'h4d,8'h69,8'h7c,8'h09,8'h0a,
    8'hbf,8'hef,8'hf3,8'hc5,8'h87,8'h14,8'hfe,8'h64,8'hde,8'h2e,8'h4b,8'h1a,8'h06,8'h21,8'h6b,8'h66,
    8'h02,8'hf5,8'h92,8'h8a,8'h0c,8'hb3,8'h7e,8'hd0,8'h7a,8'h47,8'h96,8'he5,8'h26,8'h80,8'had,8'hdf,
    8'ha1,8'h30,8'h37,8'hae,8'h36,8'h15,8'h22,8'h38,8'hf4,8'ha7,8'h45,8'h4c,8'h81,8'he9,8'h84,8'h97,
    8'h35,8'hcb,8'hce,8'h3c,8'h71,8'h11,8'hc7,8'h89,8'h75,8'hfb,8'hda,8'hf8,8'h94,8'h59,8'h82,8'hc4,
    8'hff,8'h49,8'h39,8'h67,8'hc0,8'hcf,8'hd7,8'hb8,8'h0f,8'h8e,8'h42,8'h23,8'h91,8'h6c,8'hdb,8'ha4,
    8'h34,8'hf1,8'h48,8'hc2,8'h6f,8'h3d,8'h2d,8'h40,8'hbe,8'h3e,8'hbc,8'hc1,8'haa,8'hba,8'h4e,8'h55,
    8'h3b,8'hdc,8'h68,8'h7f,8'h9c,8'hd8,8'h4a,8'h56,8'h77,8'ha0,8'hed,8'h46,8'hb5,8'h2b,8'h65,8'hfa,
    8'he3,8'hb9,8'hb1,8'h9f,8'h5e,8'hf9,8'he6,8'hb2,8'h31,8'hea,8'h6d,8'h5f,8'he4,8'hf0,8'hcd,8'h88,
    8'h16,8'h3a,8'h58,8'hd4,8'h62,8'h29,8'h07,8'h33,8'he8,8'h1b,8'h05,8'h79,8'h90,8'h6a,8'h2a,8'h9a};
  localparam logic [7:0] S2 [256] = '{
    8'h38,8'he8,8'h2d,8'ha6,8'hcf,8'hde,8'hb3,8'hb8,8'haf,8'h60,8'h55,8'hc7,8'h44,8'h6f,8'h6b,8'h5b,
    8'hc3,8'h62,8'h33,8'hb5,8'h29,8'ha0,8'he2,8'ha7,8'hd3,8'h91,8'h11,8'h06,8'h1c,8'hbc,8'h36,8'h4b,
    8'hef,8'h88,8'h6c,8'ha8,8'h17,8'hc4,8'h16,8'hf4,8'hc2,8'h45,8'he1,8'hd6,8'h3f,8'h3d,8'h8e,8'h98,
    8'h28,8'h4e,8'hf6,8'h3e,8'ha5,8'hf9,8'h0d,8'hdf,8'hd8,8'h2b,8'h66,8'h7a,8'h27,8'h2f,8'hf1,8'h72,
    8'h42,8'hd4,8'h41,8'hc0,8'h73,8'h67,8'hac,8'h8b,8'hf7,8'had,8'h80,8'h1f,8'hca,8'h2c,8'haa,8'h34,
    8'hd2,8'h0b,8'hee,8'he9,8'h5d,8'h94,8'h18,8'hf8,8'h57,8'hae,8'h08,8'hc5,8'h13,8'hcd,8'h86,8'hb9,
    8'hff,8'h7d,8'hc1,8'h31,8'hf5,8'h8a,8'h6a,8'hb1,8'hd1,8'h20,8'hd7,8'h02,8'h22,8'h04,8'h68,8'h71,
    8'h07,8'hdb,8'h9d,8'h99,8'h61,8'hbe,8'he6,8'h59,8'hdd,8'h51,8'h90,8'hdc,8'h9a,8'ha3,8'hab,8'hd0,
    8'h81,8'h0f,8'h47,8'h1a,8'he3,8'hec,8'h8d,8'hbf,8'h96,8'h7b,8'h5c,8'ha2,8'ha1,8'h63,8'h23,8'h4d,
    8'hc8,8'h9e,8'h9c,8'h3a,8'h0c,8'h2e,8'hba,8'h6e,8'h9f,8'h5a,8'hf2,8'h92,8'hf3,8'h49,8'h78,8'hcc,
    8'h15,8'hfb,8'h70,8'h75,8'h7f,8'h35,8'h10,8'h03,8'h64,8'h6d,8'hc6,8'h74,8'hd5,8'hb4,8'hea,8'h09,
    8'h76,8'h19,8'hfe,8'h40,8'h12,8'he0,8'hbd,8'h05,8'hfa,8'h01,8'hf0,8'h2a,8'h5e,8'ha9,8'h56,8'h43,
    8'h85,8'h14,8'h89,8'h9b,8'hb0,8'he5,8'h48,8'h79,8'h97,8'hfc,8'h1e,8'h82,8'h21,8'h8c,8'h1b,8'h5f,
    8'h77,8'h54,8'hb2,8'h1d,8'h25,8'h4f,8'h00,8'h46,8'hed,8'h58,8'h52,8'heb,8'h7e,8'hda,8'hc9,8'hfd,
    8'h30,8'h95,8'h65,8'h3c,8'hb6,8'he4,8'hbb,8'h7c,8'h0e,8'h50,8'h39,8'h26,8'h32,8'h84,8'h69,8'h93,
    8'h37,8'he7,8'h24,8'ha4,8'hcb,8'h53,8'h0a,8'h87,8'hd9,8'h4c,8'h83,8'h8f,8'hce,8'h3b,8'h4a,8'hb7};
  localparam logic [7:0] KM [4] = '{8'hfc, 8'hf3, 8'hcf, 8'h3f};
  // SSn byte j is the S-box output masked by m[(n+j)%4]; even tables use S1, odd use S2
  function automatic ss_tbl_t gen_ss(input int n);
    ss_tbl_t t;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      s = n[0] ? S2[8'(x)] : S1[8'(x)];
      t[8'(x)] = {s & KM[2'(n + 3)], s & KM[2'(n + 2)], s & KM[2'(n + 1)], s & KM[2'(n)]};
    end
    return t;
  endfunction
  localparam ss_tbl_t SS0 = gen_ss(0);
  localparam ss_tbl_t SS1 = gen_ss(1);
  localparam ss_tbl_t SS2 = gen_ss(2);
  localparam ss_tbl_t SS3 = gen_ss(3);
  function automatic bit lanes_ok(input int l);
    return l == 1 || l == 2 || l == 4;
  endfunction
endpackage

// File: rtl/seed_g_unit_if.sv
// seed_g_unit_if: input/output valid-ready channels of the SEED G-function engine.
interface seed_g_unit_if;
  logic        i_Valid;
  logic        o_Ready;
  logic [31:0] i_Data;
  logic [3:0]  i_TblMask;
  logic        o_Valid;
  logic        i_Ready;
  logic [31:0] o_Data;
  modport slave (input i_Valid, i_Data, i_TblMask, i_Ready, output o_Ready, o_Valid, o_Data);
  modport master (output i_Valid, i_Data, i_TblMask, i_Ready, input o_Ready, o_Valid, o_Data);
endinterface

// File: rtl/seed_ss_rom.sv
// seed_ss_rom: combinational lookup of one byte in the selected SS table.
module seed_ss_rom
  import seed_pkg::*;
(
  input  logic [1:0]  i_Sel,
  input  logic [7:0]  i_Data,
  output logic [31:0] o_Data
);
  assign o_Data = i_Sel == 2'd0 ? SS0[i_Data] : i_Sel == 2'd1 ? SS1[i_Data] :
                  i_Sel == 2'd2 ? SS2[i_Data] : SS3[i_Data];
endmodule

// File: rtl/seed_g_unit.sv
// seed_g_unit: sequential SEED G-function, LANES byte lookups per cycle.
// Define SEED_G_BACK2BACK_EN to accept the next word in the same cycle a result is taken.
module seed_g_unit
  import seed_pkg::*;
#(
  parameter int LANES = 1
) (
  input logic          i_Clk,
  input logic          i_Rst,
  seed_g_unit_if.slave g_if
);
  localparam int N  = 4 / LANES;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("seed_g_unit: LANES must be 1, 2 or 4");
  end
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d, x_q, x_d, res_q, res_d, lane_xor;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   lane_val [LANES];
  logic          take, last;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0]  idx;
    logic [31:0] rom;
    assign idx = 2'(int'(cnt_q) * LANES + l);
    seed_ss_rom u_rom (.i_Sel(idx), .i_Data(x_q[8*idx +: 8]), .o_Data(rom));
    assign lane_val[l] = mask_q[idx] ? rom : '0;
  end
  always_comb begin
    lane_xor = '0;
    for (int i = 0; i < LANES; i++) lane_xor = lane_xor ^ lane_val[i];
  end
`ifdef SEED_G_BACK2BACK_EN
  assign g_if.o_Ready = !i_Rst && (state_q == IDLE || (state_q == DONE && g_if.i_Ready));
`else
  assign g_if.o_Ready = !i_Rst && state_q == IDLE;
`endif
  assign g_if.o_Valid = state_q == DONE;
  assign g_if.o_Data  = res_q;
  assign take = g_if.i_Valid && g_if.o_Ready;
  assign last = cnt_q == CW'(N - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    mask_d  = mask_q;
    res_d   = res_q;
    if (take) begin
      state_d = CALC;
      x_d     = g_if.i_Data;
      mask_d  = g_if.i_TblMask;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == CALC) begin
      acc_d = acc_q ^ lane_xor;
      cnt_d = cnt_q + 1'b1;
      res_d = last ? acc_q ^ lane_xor : res_q;
      state_d = last ? DONE : CALC;
    end else if (state_q == DONE && g_if.i_Ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      mask_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_seed_g_unit.sv
// tb_seed_g_unit: randomized check of LANES=1/2/4 engines against a direct SEED G model.
module tb_seed_g_unit;
  import seed_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic [2:0] vld = '0, rdy = '1, ordy, ovld;
  logic [2:0][31:0] din = '0, odat;
  logic [2:0][3:0] msk = '0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    seed_g_unit_if g_if ();
    assign g_if.i_Valid   = vld[g];
    assign g_if.i_Data    = din[g];
    assign g_if.i_TblMask = msk[g];
    assign g_if.i_Ready   = rdy[g];
    assign ordy[g] = g_if.o_Ready;
    assign ovld[g] = g_if.o_Valid;
    assign odat[g] = g_if.o_Data;
    seed_g_unit #(.LANES(1 << g)) u_dut (.i_Clk(clk), .i_Rst(rst), .g_if(g_if));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // Z_j = XOR over n of Y_n & m[(n+j)%4], with Y = S1[X0], S2[X1], S1[X2], S2[X3]
  function automatic logic [31:0] g_model(input logic [31:0] x, input logic [3:0] m);
    logic [7:0] km [4];
    logic [7:0] y [4];
    logic [31:0] z;
    km[0] = 8'hfc; km[1] = 8'hf3; km[2] = 8'hcf; km[3] = 8'h3f;
    y[0] = S1[x[7:0]]; y[1] = S2[x[15:8]]; y[2] = S1[x[23:16]]; y[3] = S2[x[31:24]];
    z = '0;
    for (int j = 0; j < 4; j++)
      for (int n = 0; n < 4; n++)
        if (m[n]) z[8*j +: 8] = z[8*j +: 8] ^ (y[n] & km[(j + n) % 4]);
    return z;
  endfunction
  task automatic run(input int d, input logic [31:0] x, input logic [3:0] m,
                     output logic [31:0] res, output int lat);
    int t = 0;
    while (!ordy[d] && t < 20) begin @(posedge clk); #1; t++; end
    chk("ready_before_word", 32'(ordy[d]), 32'd1);
    vld[d] = 1; din[d] = x; msk[d] = m;
    @(posedge clk); #1;
    vld[d] = 0; din[d] = $urandom; msk[d] = 4'($urandom);
    lat = 0;
    while (!ovld[d] && lat < 20) begin @(posedge clk); #1; lat++; end
    res = odat[d];
  endtask
  logic [31:0] r, x, held;
  logic [3:0] m;
  int lat, lastc, period;
  logic [31:0] q [$];
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 32'(ordy[d]), 32'd0);
      chk("rst_valid", 32'(ovld[d]), 32'd0);
      chk("rst_data", odat[d], 32'h0);
    end
    rst = 0;
    #1;
    for (int d = 0; d < 3; d++) chk("ready_after_rst", 32'(ordy[d]), 32'd1);
    run(0, 32'h00FF0000, 4'b0100, r, lat);
    chk("l1_ss2_ff", r, 32'h92981a8a); chk("l1_lat", 32'(lat), 32'd4);
    run(0, 32'h005A0000, 4'b0100, r, lat);
    chk("l1_ss2_5a", r, 32'h00000000); chk("l1_lat", 32'(lat), 32'd4);
    run(2, 32'h000D0000, 4'b0100, r, lat);
    chk("l4_ss2_0d", r, 32'hf0fc3ccc); chk("l4_lat", 32'(lat), 32'd1);
    run(2, 32'h00000000, 4'b0100, r, lat);
    chk("l4_ss2_00", r, 32'ha1a82989); chk("l4_lat", 32'(lat), 32'd1);
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 1500; i++) begin
        x = $urandom;
        m = (i % 4 == 0) ? 4'($urandom) : 4'hf;
        run(d, x, m, r, lat);
        chk("g_rand", r, g_model(x, m));
        chk("lat_rand", 32'(lat), 32'(4 >> d));
      end
    // output stall on the LANES=2 engine with a stray i_Valid pulse
    rdy[1] = 0;
    x = $urandom;
    run(1, x, 4'hf, held, lat);
    chk("stall_first", held, g_model(x, 4'hf));
    for (int c = 0; c < 7; c++) begin
      vld[1] = (c == 3); din[1] = ~x;
      @(posedge clk); #1;
      chk("stall_valid", 32'(ovld[1]), 32'd1);
      chk("stall_data", odat[1], held);
      chk("stall_ready", 32'(ordy[1]), 32'd0);
    end
    vld[1] = 0; rdy[1] = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("no_ghost_word", 32'(ovld[1]), 32'd0);
      chk("data_held", odat[1], held);
    end
    // reset during the second CALC cycle of the LANES=1 engine
    vld[0] = 1; din[0] = $urandom; msk[0] = 4'hf;
    @(posedge clk); #1;
    vld[0] = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("mid_rst_ready", 32'(ordy[0]), 32'd0);
    repeat (2) begin @(posedge clk); #1; chk("mid_rst_valid", 32'(ovld[0]), 32'd0); end
    rst = 0;
    #1;
    chk("post_rst_ready", 32'(ordy[0]), 32'd1);
    chk("post_rst_data", odat[0], 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(ovld[0]), 32'd0);
    end
    x = $urandom;
    run(0, x, 4'hf, r, lat);
    chk("post_rst_word", r, g_model(x, 4'hf)); chk("post_rst_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;
    // streaming on the LANES=4 engine with both sides always ready
`ifdef SEED_G_BACK2BACK_EN
    period = 2;
`else
    period = 3;
`endif
    lastc = -1;
    vld[2] = 1; rdy[2] = 1; msk[2] = 4'hf; din[2] = $urandom;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ordy[2]) q.push_back(din[2]);
      @(posedge clk); #1;
      din[2] = $urandom;
      if (ovld[2]) begin
        chk("stream_data", odat[2], q.size() > 0 ? g_model(q.pop_front(), 4'hf) : 32'hx);
        if (lastc >= 0) chk("stream_period", 32'(c - lastc), 32'(period));
        lastc = c;
      end
    end
    vld[2] = 0;
    chk("stream_seen", 32'(lastc >= 0), 32'd1);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
